// File: rtl/mbisr_pkg.sv
// Shared state encoding and default sizing for the MBISR repair/remap stage.
package mbisr_pkg;

   localparam int ADDR_W_DEF     = 4;
   localparam int DATA_W_DEF     = 8;
   localparam int NUM_SPARES_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COLLECT  = 2'd1,
      S_REPAIRED = 2'd2,
      S_FAIL     = 2'd3
   } state_e;

endpackage

// File: rtl/mbisr_repair_remap_if.sv
// Functional access bus plus main-array port; master = requester/array side, slave = repair stage.
interface mbisr_repair_remap_if
   import mbisr_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              acc_en;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [DATA_W-1:0] acc_rdata;
   logic              acc_rvalid;
   logic              acc_busy;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output acc_en, acc_we, acc_addr, acc_wdata, mem_rdata,
      input  acc_rdata, acc_rvalid, acc_busy, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  acc_en, acc_we, acc_addr, acc_wdata, mem_rdata,
      output acc_rdata, acc_rvalid, acc_busy, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mbisr_spare_table.sv
// Spare word table: valid-qualified tags, spare data, parallel match and lowest-free allocator.
module mbisr_spare_table
   import mbisr_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int NUM_SPARES = NUM_SPARES_DEF,
   parameter int IDX_W      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
   parameter int CNT_W      = $clog2(NUM_SPARES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              log_en,
   input  logic [ADDR_W-1:0] log_addr,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] lk_addr,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              lk_hit,
   output logic [IDX_W-1:0]  lk_idx,
   output logic              log_dup,
   output logic              full,
   output logic [CNT_W-1:0]  used,
   output logic [DATA_W-1:0] rd_data
);

   logic [NUM_SPARES-1:0] valid;
   logic [ADDR_W-1:0]     tag  [NUM_SPARES];
   logic [DATA_W-1:0]     data [NUM_SPARES];
   logic [IDX_W-1:0]      free_idx;

   // full starts set and drops at the first free slot, so free_idx lands on the lowest one
   always_comb begin
      lk_hit   = 1'b0;
      lk_idx   = '0;
      log_dup  = 1'b0;
      full     = 1'b1;
      free_idx = '0;
      used     = '0;
      for (int unsigned i = 0; i < NUM_SPARES; i++) begin
         if (valid[i] && tag[i] == lk_addr) begin
            lk_hit = 1'b1;
            lk_idx = IDX_W'(i);
         end
         if (valid[i] && tag[i] == log_addr) log_dup = 1'b1;
         if (valid[i]) used = used + CNT_W'(1);
         if (!valid[i] && full) begin
            full     = 1'b0;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int unsigned i = 0; i < NUM_SPARES; i++) begin
            tag[i]  <= '0;
            data[i] <= '0;
         end
      end else if (clear) begin
         valid <= '0;
      end else begin
         if (log_en && !log_dup && !full) begin
            valid[free_idx] <= 1'b1;
            tag[free_idx]   <= log_addr;
            data[free_idx]  <= '0;
         end
         if (wr_en) data[wr_idx] <= wr_data;
      end
   end

   assign rd_data = data[rd_idx];

endmodule

// File: rtl/mbisr_repair_remap.sv
// MBISR stage: logs failing addresses during BIST, then remaps hits onto spare words.
module mbisr_repair_remap
   import mbisr_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int NUM_SPARES = NUM_SPARES_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               bist_start,
   input  logic                               bist_done,
   input  logic                               fail_valid,
   input  logic [ADDR_W-1:0]                  fail_addr,
   mbisr_repair_remap_if.slave                bus,
   output logic                               repair_ok,
   output logic                               repair_fail,
   output logic [$clog2(NUM_SPARES+1)-1:0]    spares_used
);

   localparam int IDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;
   localparam int CNT_W = $clog2(NUM_SPARES + 1);

   state_e            state, state_nxt;
   logic              overflow, log_en, ovf_now;
   logic              lk_hit, log_dup, full;
   logic [IDX_W-1:0]  lk_idx, rd_idx;
   logic              acc_go, hit, remap_on;
   logic              rd_pend, rd_hit;
   logic [DATA_W-1:0] rdata_q, spare_rd;

   assign log_en  = (state == S_COLLECT) && fail_valid && !bist_start;
   assign ovf_now = log_en && !log_dup && full;

   mbisr_spare_table #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .NUM_SPARES (NUM_SPARES),
      .IDX_W      (IDX_W),
      .CNT_W      (CNT_W)
   ) u_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bist_start),
      .log_en   (log_en),
      .log_addr (fail_addr),
      .wr_en    (hit && bus.acc_we),
      .wr_idx   (lk_idx),
      .wr_data  (bus.acc_wdata),
      .lk_addr  (bus.acc_addr),
      .rd_idx   (rd_idx),
      .lk_hit   (lk_hit),
      .lk_idx   (lk_idx),
      .log_dup  (log_dup),
      .full     (full),
      .used     (spares_used),
      .rd_data  (spare_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          overflow <= 1'b0;
      else if (bist_start) overflow <= 1'b0;
      else if (ovf_now)    overflow <= 1'b1;
   end

   // a fail arriving with bist_done is folded into the verdict via ovf_now
   always_comb begin
      state_nxt = state;
      if (bist_start)
         state_nxt = S_COLLECT;
      else if (state == S_COLLECT && bist_done)
         state_nxt = (overflow || ovf_now) ? S_FAIL : S_REPAIRED;
   end

   always_comb begin
      repair_ok     = (state == S_REPAIRED) && !bist_start;
      repair_fail   = (state == S_FAIL) && !bist_start;
      bus.acc_busy  = (state == S_COLLECT);
      remap_on      = (state == S_REPAIRED);
      acc_go        = bus.acc_en && (state != S_COLLECT);
      hit           = acc_go && remap_on && lk_hit;
      bus.mem_en    = acc_go && !hit;
      bus.mem_we    = acc_go && !hit && bus.acc_we;
      bus.mem_addr  = (acc_go && !hit) ? bus.acc_addr : '0;
      bus.mem_wdata = (acc_go && !hit && bus.acc_we) ? bus.acc_wdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
         rd_hit  <= 1'b0;
         rd_idx  <= '0;
         rdata_q <= '0;
      end else begin
         rd_pend <= acc_go && !bus.acc_we;
         rd_hit  <= hit;
         rd_idx  <= lk_idx;
         if (rd_pend) rdata_q <= bus.acc_rdata;
      end
   end

   assign bus.acc_rvalid = rd_pend;
   assign bus.acc_rdata  = rd_pend ? (rd_hit ? spare_rd : bus.mem_rdata) : rdata_q;

endmodule
